codificador_indices: RTL and testbench

Inverse of `gerador_indices`: takes a 4-element permutation of {0,1,2,3} and computes its lexicographic rank (0..23) by an iterative Lehmer-code walk over several clock cycles.
Its output is zero-extended to the generator's `entrada` width, so a generator→encoder loop returns the original index.
It sits on the consumer side of the permutation bus and is started by a single-cycle request.
It flags non-permutation inputs when checking is compiled in.

---
 rtl/codificador_indices.sv | 174 +++++++++++++++++
 tb/tb_codificador_indices.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/codificador_indices.sv
// codificador_indices
//
// Takes a 4-element permutation of {0,1,2,3} and computes its lexicographic
// rank (0..23) over several clock cycles. It walks the Lehmer code: for
// position i it counts the later elements that are smaller than element i,
// and weights that count by the factorial of the number of remaining
// positions (6, 2, 1). The rank is the inverse of gerador_indices, so feeding
// the generator output back in returns the original index.
//
// Optional feature: define CHECAGEM_PERM_EN to include the CHECK state.
// CHECK flags inputs that repeat an element. Without the macro, IDLE goes
// straight to C0, the result arrives one cycle earlier, and erro is tied to 0.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous, active-low reset
//   iniciar  - start request, sampled only while idle
//   perm     - permutation; perm[7:6] is element 0, perm[1:0] is element 3
//   indice   - rank in bits [4:0], zero-extended to SAIDA_W; held until the next result
//   pronto   - one-cycle pulse; indice/erro are valid in that cycle
//   ocupado  - high whenever the block is not idle
//   erro     - latched input was not a permutation (checking builds only)
module codificador_indices #(
  parameter int SAIDA_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [7:0]         perm,
  output logic [SAIDA_W-1:0] indice,
  output logic               pronto,
  output logic               ocupado,
  output logic               erro
);

  typedef enum logic [2:0] {
    IDLE,
`ifdef CHECAGEM_PERM_EN
    CHECK,
`endif
    C0,
    C1,
    C2,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           perm_q, perm_d;
  logic [4:0]           acc_q, acc_d;
  logic [SAIDA_W-1:0]   indice_q, indice_d;
`ifdef CHECAGEM_PERM_EN
  logic                 erro_q, erro_d;
  logic                 dup;
`endif

  logic [1:0] elem [4];
  logic [1:0] d0, d1, d2;
  logic [4:0] term;
  logic [4:0] sum;

  assign elem[0] = perm_q[7:6];
  assign elem[1] = perm_q[5:4];
  assign elem[2] = perm_q[3:2];
  assign elem[3] = perm_q[1:0];

  // Lehmer digits: the number of later elements smaller than element i.
  assign d0 = {1'b0, elem[1] < elem[0]} + {1'b0, elem[2] < elem[0]} + {1'b0, elem[3] < elem[0]};
  assign d1 = {1'b0, elem[2] < elem[1]} + {1'b0, elem[3] < elem[1]};
  assign d2 = {1'b0, elem[3] < elem[2]};

`ifdef CHECAGEM_PERM_EN
  // Four 2-bit values form a permutation exactly when no pair repeats.
  assign dup = (elem[0] == elem[1]) || (elem[0] == elem[2]) || (elem[0] == elem[3]) ||
               (elem[1] == elem[2]) || (elem[1] == elem[3]) || (elem[2] == elem[3]);
`endif

  // Weighted digit for the current step. d0*6 is built as d0*4 + d0*2.
  always_comb begin
    term = 5'd0;
    case (state_q)
      C0:      term = {1'b0, d0, 2'b00} + {2'b00, d0, 1'b0};
      C1:      term = {2'b00, d1, 1'b0};
      C2:      term = {3'b000, d2};
      default: term = 5'd0;
    endcase
  end

  // The largest digits are 3, 2 and 1, so the sum is at most 23.
  // That always fits in 5 bits.
  assign sum = acc_q + term;

  always_comb begin
    state_d  = state_q;
    perm_d   = perm_q;
    acc_d    = acc_q;
    indice_d = indice_q;
`ifdef CHECAGEM_PERM_EN
    erro_d   = erro_q;
`endif
    case (state_q)
      IDLE: begin
        if (iniciar) begin
          perm_d  = perm;
          acc_d   = 5'd0;
`ifdef CHECAGEM_PERM_EN
          state_d = CHECK;
`else
          state_d = C0;
`endif
        end
      end
`ifdef CHECAGEM_PERM_EN
      CHECK: begin
        if (dup) begin
          acc_d    = 5'd0;
          indice_d = '0;
          erro_d   = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = C0;
        end
      end
`endif
      C0: begin
        acc_d   = sum;
        state_d = C1;
      end
      C1: begin
        acc_d   = sum;
        state_d = C2;
      end
      C2: begin
        acc_d    = sum;
        indice_d = SAIDA_W'(sum);
`ifdef CHECAGEM_PERM_EN
        erro_d   = 1'b0;
`endif
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      perm_q   <= 8'd0;
      acc_q    <= 5'd0;
      indice_q <= '0;
`ifdef CHECAGEM_PERM_EN
      erro_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      perm_q   <= perm_d;
      acc_q    <= acc_d;
      indice_q <= indice_d;
`ifdef CHECAGEM_PERM_EN
      erro_q   <= erro_d;
`endif
    end
  end

  assign indice  = indice_q;
  assign ocupado = (state_q != IDLE);
  assign pronto  = (state_q == DONE);
`ifdef CHECAGEM_PERM_EN
  assign erro    = erro_q;
`else
  assign erro    = 1'b0;
`endif

endmodule

// File: tb/tb_codificador_indices.sv
// tb_codificador_indices
//
// Bench for codificador_indices. The reference is a table of all 24
// permutations in lexicographic order. A value's rank is its position in
// that table. A value that is not in the table is not a permutation.
module tb_codificador_indices;

  localparam int SW = 16;
`ifdef CHECAGEM_PERM_EN
  localparam int LAT = 4;
  localparam bit CHK = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit CHK = 1'b0;
`endif

  logic          clock   = 1'b0;
  logic          reset   = 1'b0;
  logic          iniciar = 1'b0;
  logic [7:0]    perm    = 8'd0;
  logic [SW-1:0] indice;
  logic          pronto;
  logic          ocupado;
  logic          erro;

  int total = 0;
  int bad   = 0;

  logic [7:0] perm_table [24];

  codificador_indices #(.SAIDA_W(SW)) dut (
    .clock   (clock),
    .reset   (reset),
    .iniciar (iniciar),
    .perm    (perm),
    .indice  (indice),
    .pronto  (pronto),
    .ocupado (ocupado),
    .erro    (erro)
  );

  always #5 clock = ~clock;

  function automatic int rankOf(input logic [7:0] p);
    for (int r = 0; r < 24; r++)
      if (perm_table[r] === p) return r;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts one operation and then follows it until pronto or a cycle budget
  // runs out. lat counts the clock edges from the accepting edge to the
  // first cycle in which pronto is seen.
  task automatic applyStimulus(input logic [7:0] p, output int lat,
                               output logic [SW-1:0] idx, output logic er,
                               output logic busy);
    lat  = -1;
    idx  = 'x;
    er   = 1'bx;
    busy = 1'bx;
    @(negedge clock);
    perm    = p;
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    perm    = 8'($urandom);
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (n == 0) busy = ocupado;
      if (pronto === 1'b1) begin
        lat = n;
        idx = indice;
        er  = erro;
        break;
      end
    end
  endtask

  task automatic verifyOp(input logic [7:0] p, input string tag);
    int            lat, r, exp_lat;
    logic [SW-1:0] idx;
    logic          er, busy, exp_er;
    r       = rankOf(p);
    exp_lat = (r < 0 && CHK) ? 1 : LAT;
    exp_er  = (r < 0) && CHK;
    applyStimulus(p, lat, idx, er, busy);
    checkOutput({tag, " ocupado"}, 32'(busy), 32'd1);
    checkOutput({tag, " latency"}, lat, exp_lat);
    checkOutput({tag, " erro"}, 32'(er), 32'(exp_er));
    if (r < 0 && !CHK)
      checkOutput({tag, " indice range"}, 32'(idx <= 23), 32'd1);
    else
      checkOutput({tag, " indice"}, 32'(idx), (r < 0) ? 32'd0 : 32'(r));
    @(negedge clock);
    checkOutput({tag, " pronto single"}, 32'(pronto), 32'd0);
    checkOutput({tag, " indice held"}, 32'(indice), 32'(idx));
  endtask

  initial begin
    int            k, lat, pulses;
    logic [SW-1:0] idx;
    logic [7:0]    p;
    logic [7:0]    directed [5];

    k = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++)
            if (a != b && a != c && a != d && b != c && b != d && c != d) begin
              perm_table[k] = {2'(a), 2'(b), 2'(c), 2'(d)};
              k++;
            end

    $display("[TB] reset");
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset indice", 32'(indice), 32'd0);
    checkOutput("reset pronto", 32'(pronto), 32'd0);
    checkOutput("reset ocupado", 32'(ocupado), 32'd0);
    checkOutput("reset erro", 32'(erro), 32'd0);

    $display("[TB] directed permutations");
    directed[0] = 8'b00_01_10_11;
    directed[1] = 8'b00_01_11_10;
    directed[2] = 8'b00_10_11_01;
    directed[3] = 8'b10_00_01_11;
    directed[4] = 8'b11_10_01_00;
    for (int i = 0; i < 5; i++)
      verifyOp(directed[i], $sformatf("directed%0d", i));

    $display("[TB] generator round trip");
    for (int r = 0; r < 24; r++)
      verifyOp(perm_table[r], $sformatf("rank%0d", r));

    $display("[TB] duplicate input");
    verifyOp(8'b01_01_10_11, "duplicate");

    $display("[TB] random inputs");
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1)
        p = perm_table[$urandom_range(0, 23)];
      else
        p = 8'($urandom);
      verifyOp(p, $sformatf("random%0d", i));
    end

    $display("[TB] start pulse while busy");
    @(negedge clock);
    perm    = perm_table[9];
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    perm    = 8'hAA;
    pulses  = 0;
    lat     = -1;
    idx     = 'x;
    for (int n = 0; n < LAT + 10; n++) begin
      @(negedge clock);
      if (pronto === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          idx = indice;
        end
      end
      if (n == LAT - 2) begin
        iniciar = 1'b1;
        perm    = perm_table[17];
      end else begin
        iniciar = 1'b0;
      end
    end
    checkOutput("busy latency", lat, LAT);
    checkOutput("busy indice", 32'(idx), 32'd9);
    checkOutput("busy pronto count", pulses, 1);

    $display("[TB] reset mid operation");
    @(negedge clock);
    perm    = perm_table[5];
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    for (int n = 0; n <= LAT - 3; n++) @(negedge clock);
    checkOutput("abort busy before", 32'(ocupado), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort ocupado", 32'(ocupado), 32'd0);
    checkOutput("abort pronto", 32'(pronto), 32'd0);
    checkOutput("abort indice", 32'(indice), 32'd0);
    checkOutput("abort erro", 32'(erro), 32'd0);
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (pronto === 1'b1) pulses++;
    end
    checkOutput("abort no pronto", pulses, 0);
    verifyOp(perm_table[20], "after abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
